dmem_responder: RTL and testbench

- Handshaked, multi-cycle data-memory target: the responder end of the processor's load/store interface.
- Accepts one request (load or store, byte/half/word/double) via valid/ready, waits a fixed latency, performs the access, and returns a response via valid/ready.
- Sits behind the processor's memory stage in place of the single-cycle data memory; models realistic memory timing for the multi-cycle/pipelined core.

---
 rtl/dmem_responder_pkg.sv | 48 ++++
 rtl/dmem_responder_if.sv | 28 ++
 rtl/dmem_responder_load_align.sv | 36 +++
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 tb/tb_dmem_responder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the handshaked data-memory responder.
package dmem_responder_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              write;
        size_e             size;
        logic              is_unsigned;
        logic [DATA_W-1:0] wdata;
    } req_attr_t;

    function automatic logic is_misaligned(logic [2:0] lane, size_e size);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return lane[0];
            SZ_W:    return |lane[1:0];
            default: return |lane;
        endcase
    endfunction

    // Byte enables of an aligned access within its doubleword.
    function automatic logic [7:0] lane_mask(logic [2:0] lane, size_e size);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << lane;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request/response bus between the memory stage and the responder.
interface dmem_responder_if #(
    parameter int unsigned ADDR_WIDTH = 10
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [63:0]           req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [63:0]           rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_responder_load_align.sv
// Extracts a byte/half/word/double from a doubleword and sign- or zero-extends it.
module dmem_responder_load_align
    import dmem_responder_pkg::*;
(
    input  logic [63:0] dword_i,
    input  logic [2:0]  lane_i,
    input  size_e       size_i,
    input  logic        unsigned_i,
    output logic [63:0] data_o
);

    logic [63:0] shifted;
    logic        sext;

    always_comb begin
        shifted = dword_i >> {lane_i, 3'b000};
        sext    = 1'b0;
        data_o  = shifted;
        case (size_i)
            SZ_B: begin
                sext   = ~unsigned_i & shifted[7];
                data_o = {{56{sext}}, shifted[7:0]};
            end
            SZ_H: begin
                sext   = ~unsigned_i & shifted[15];
                data_o = {{48{sext}}, shifted[15:0]};
            end
            SZ_W: begin
                sext   = ~unsigned_i & shifted[31];
                data_o = {{32{sext}}, shifted[31:0]};
            end
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: accepts one load/store, waits LATENCY edges,
// performs the access and holds the response until the initiator consumes it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned LATENCY    = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MEM_BYTES = DEPTH * 8;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  accept_c;
    logic                  access_c;

    req_attr_t             attr_q, live_attr, acc_attr;
    logic [ADDR_WIDTH-1:0] addr_q, acc_addr;

    logic [63:0]           mem_q [DEPTH];
    logic [IDX_W-1:0]      idx;
    logic [2:0]            lane;
    logic                  err_c;
    logic [63:0]           rd_dword;
    logic [63:0]           load_data;
    logic [63:0]           wshift;
    logic [7:0]            be;
    logic [63:0]           merged;

    logic [63:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and strobe decode from state
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        accept_c      = 1'b0;
        access_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                accept_c      = bus.req_valid;
                access_c      = bus.req_valid && (LATENCY == 1);
            end
            ST_BUSY: access_c = (cnt_q == CNT_W'(1));
            ST_RESP: bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // With LATENCY==1 the access happens on the acceptance edge, so use live inputs.
    assign live_attr = '{write:       bus.req_write,
                         size:        size_e'(bus.req_size),
                         is_unsigned: bus.req_unsigned,
                         wdata:       bus.req_wdata};
    assign acc_attr  = (state_q == ST_IDLE) ? live_attr    : attr_q;
    assign acc_addr  = (state_q == ST_IDLE) ? bus.req_addr : addr_q;

    assign lane     = acc_addr[2:0];
    assign idx      = IDX_W'(acc_addr >> 3);
    assign err_c    = is_misaligned(lane, acc_attr.size) || (32'(acc_addr) >= MEM_BYTES);
    assign rd_dword = mem_q[idx];

    dmem_responder_load_align u_align (
        .dword_i    (rd_dword),
        .lane_i     (lane),
        .size_i     (acc_attr.size),
        .unsigned_i (acc_attr.is_unsigned),
        .data_o     (load_data)
    );

    // Store byte merge into the addressed doubleword
    always_comb begin
        be     = lane_mask(lane, acc_attr.size);
        wshift = acc_attr.wdata << {lane, 3'b000};
        merged = rd_dword;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) merged[b*8 +: 8] = wshift[b*8 +: 8];
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (access_c) begin
            err_d   = err_c;
            rdata_d = (err_c || acc_attr.write) ? 64'd0 : load_data;
        end
    end

    // Request latch and registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            attr_q  <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept_c) begin
                attr_q <= live_attr;
                addr_q <= bus.req_addr;
            end
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (access_c && acc_attr.write && !err_c) begin
            mem_q[idx] <= merged;
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance driven through a
// queue-backed monitor, plus a small LATENCY=1, DEPTH=64 instance.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    dmem_responder_if #(.ADDR_WIDTH(10)) bus0 ();
    dmem_responder_if #(.ADDR_WIDTH(10)) bus1 ();

    dmem_responder #(.ADDR_WIDTH(10), .DEPTH(128), .LATENCY(2)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    dmem_responder #(.ADDR_WIDTH(10), .DEPTH(64), .LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          acc;
        string       name;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    logic prev_v = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Issue one request on bus0 from a negedge; returns at the negedge after acceptance.
    task automatic send(input string name, input logic wr, input logic [9:0] addr,
                        input logic [1:0] size, input logic uns, input logic [63:0] wdata,
                        input logic [63:0] exp_rd, input logic exp_err, input bit push);
        exp_t e;
        int   n = 0;
        bus0.req_valid    = 1'b1;
        bus0.req_write    = wr;
        bus0.req_addr     = addr;
        bus0.req_size     = size;
        bus0.req_unsigned = uns;
        bus0.req_wdata    = wdata;
        while (!bus0.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus0.req_ready) begin
            chk({name, " accept timeout"}, 64'(bus0.req_ready), 64'd1);
            bus0.req_valid = 1'b0;
            return;
        end
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.acc   = cyc;
        e.name  = name;
        if (push) sbq.push_back(e);
        @(negedge clk);
        // Scramble request inputs: the latched request must not follow them.
        bus0.req_valid = 1'b0;
        bus0.req_write = ~wr;
        bus0.req_addr  = 10'h3FF;
        bus0.req_size  = ~size;
        bus0.req_wdata = ~wdata;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard drain", 64'(sbq.size()), 64'd0);
    endtask

    // Request/response on the LATENCY=1 instance with inline checks.
    task automatic send1(input string name, input logic wr, input logic [9:0] addr,
                         input logic [1:0] size, input logic uns, input logic [63:0] wdata,
                         input logic [63:0] exp_rd, input logic exp_err);
        int acc;
        int n = 0;
        bus1.req_valid    = 1'b1;
        bus1.req_write    = wr;
        bus1.req_addr     = addr;
        bus1.req_size     = size;
        bus1.req_unsigned = uns;
        bus1.req_wdata    = wdata;
        while (!bus1.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        bus1.req_addr  = 10'h3FF;
        bus1.req_wdata = ~wdata;
        n = 0;
        while (!bus1.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, " latency"}, 64'(cyc), 64'(acc + 1));
        chk({name, " rdata"}, bus1.rsp_rdata, exp_rd);
        chk({name, " err"}, 64'(bus1.rsp_err), 64'(exp_err));
        @(negedge clk);
    endtask

    // Monitor: latency on each rising rsp_valid, data/err on each handshake.
    always @(negedge clk) begin
        #1;
        if (bus0.rsp_valid && !prev_v) begin
            if (sbq.size() == 0) chk("unexpected rsp_valid", 64'(bus0.rsp_valid), 64'd0);
            else chk({sbq[0].name, " latency"}, 64'(cyc), 64'(sbq[0].acc + 2));
        end
        if (bus0.rsp_valid && bus0.rsp_ready && sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk({mon_e.name, " rdata"}, bus0.rsp_rdata, mon_e.rdata);
            chk({mon_e.name, " err"}, 64'(bus0.rsp_err), 64'(mon_e.err));
        end
        prev_v = bus0.rsp_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_size = '0;
        bus0.req_unsigned = 1'b0; bus0.req_wdata = '0; bus0.rsp_ready = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_size = '0;
        bus1.req_unsigned = 1'b0; bus1.req_wdata = '0; bus1.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("reset req_ready", 64'(bus0.req_ready), 64'd1);
        chk("reset rsp_valid", 64'(bus0.rsp_valid), 64'd0);
        chk("reset rsp_rdata", bus0.rsp_rdata, 64'd0);
        chk("reset rsp_err", 64'(bus0.rsp_err), 64'd0);
        chk("reset L1 req_ready", 64'(bus1.req_ready), 64'd1);

        send("st D 008", 1'b1, 10'h008, 2'd3, 1'b0, 64'h0123456789ABCDEF, 64'd0, 1'b0, 1'b1);
        send("ld D 008", 1'b0, 10'h008, 2'd3, 1'b0, 64'd0, 64'h0123456789ABCDEF, 1'b0, 1'b1);
        send("st B 013", 1'b1, 10'h013, 2'd0, 1'b0, 64'hAAAAAAAAAAAAAA80, 64'd0, 1'b0, 1'b1);
        send("ld B s 013", 1'b0, 10'h013, 2'd0, 1'b0, 64'd0, 64'hFFFFFFFFFFFFFF80, 1'b0, 1'b1);
        send("ld B u 013", 1'b0, 10'h013, 2'd0, 1'b1, 64'd0, 64'h0000000000000080, 1'b0, 1'b1);
        send("ld D 010", 1'b0, 10'h010, 2'd3, 1'b0, 64'd0, 64'h0000000080000000, 1'b0, 1'b1);
        send("st D 020", 1'b1, 10'h020, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b0, 1'b1);
        send("st H 022", 1'b1, 10'h022, 2'd1, 1'b0, 64'hDEADBEEF55551234, 64'd0, 1'b0, 1'b1);
        send("ld D 020", 1'b0, 10'h020, 2'd3, 1'b0, 64'd0, 64'hFFFFFFFF1234FFFF, 1'b0, 1'b1);
        send("ld W s 024", 1'b0, 10'h024, 2'd2, 1'b0, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1);
        send("ld W u 024", 1'b0, 10'h024, 2'd2, 1'b1, 64'd0, 64'h00000000FFFFFFFF, 1'b0, 1'b1);
        send("ld H s 022", 1'b0, 10'h022, 2'd1, 1'b0, 64'd0, 64'h0000000000001234, 1'b0, 1'b1);
        send("st W mis 022", 1'b1, 10'h022, 2'd2, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1);
        send("ld H mis 021", 1'b0, 10'h021, 2'd1, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1);
        send("ld D 020 post", 1'b0, 10'h020, 2'd3, 1'b0, 64'd0, 64'hFFFFFFFF1234FFFF, 1'b0, 1'b1);
        wait_drain();

        // Backpressure: response held while a stray request is offered.
        bus0.rsp_ready = 1'b0;
        send("ld D bp", 1'b0, 10'h008, 2'd3, 1'b0, 64'd0, 64'h0123456789ABCDEF, 1'b0, 1'b1);
        for (int n = 0; n < 20 && !bus0.rsp_valid; n++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus0.req_valid = 1'b1;
            bus0.req_write = 1'b1;
            bus0.req_addr  = 10'h008;
            bus0.req_size  = 2'd3;
            bus0.req_wdata = 64'h0BAD0BAD0BAD0BAD;
            @(negedge clk);
            chk("bp rsp_valid", 64'(bus0.rsp_valid), 64'd1);
            chk("bp rsp_rdata", bus0.rsp_rdata, 64'h0123456789ABCDEF);
            chk("bp req_ready", 64'(bus0.req_ready), 64'd0);
        end
        bus0.req_valid = 1'b0;
        bus0.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp release req_ready", 64'(bus0.req_ready), 64'd1);
        chk("bp release rsp_valid", 64'(bus0.rsp_valid), 64'd0);
        send("ld D 008 after bp", 1'b0, 10'h008, 2'd3, 1'b0, 64'd0, 64'h0123456789ABCDEF, 1'b0, 1'b1);
        wait_drain();

        send1("L1 st D 008", 1'b1, 10'h008, 2'd3, 1'b0, 64'h0123456789ABCDEF, 64'd0, 1'b0);
        send1("L1 ld D 008", 1'b0, 10'h008, 2'd3, 1'b0, 64'd0, 64'h0123456789ABCDEF, 1'b0);
        send1("L1 ld B 00F", 1'b0, 10'h00F, 2'd0, 1'b0, 64'd0, 64'h0000000000000001, 1'b0);
        send1("L1 ld D oor", 1'b0, 10'h200, 2'd3, 1'b0, 64'd0, 64'd0, 1'b1);
        send1("L1 st D oor", 1'b1, 10'h200, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);

        // Reset while a store is in BUSY: nothing committed, no response.
        send("st D 030 aborted", 1'b1, 10'h030, 2'd3, 1'b0, 64'h5A5A5A5A5A5A5A5A, 64'd0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid-busy reset rsp_valid", 64'(bus0.rsp_valid), 64'd0);
        chk("mid-busy reset req_ready", 64'(bus0.req_ready), 64'd1);
        @(negedge clk);
        chk("mid-busy reset no late rsp", 64'(bus0.rsp_valid), 64'd0);
        send("ld D 030 after reset", 1'b0, 10'h030, 2'd3, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
        send("ld D 008 after reset", 1'b0, 10'h008, 2'd3, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
